// File: rtl/sum_display_ctrl.sv
// rtl/sum_display_ctrl.sv - add / binary-to-BCD / multiplexed seven-segment controller
//
// Purpose:
//   On start (sampled in IDLE) registers a + b + cin, converts the 9-bit sum
//   to three BCD digits with a shift-add-3 loop (one iteration per cycle, nine
//   iterations), then presents the digits through one shared seven-segment
//   decoder that is time-multiplexed across the three digit enables.
//
// Parameters:
//   SCAN_DIV  clk cycles each digit stays enabled (>= 1)
//
// Optional feature:
//   LEADING_ZERO_BLANK_EN  blanks a leading-zero hundreds digit and a leading
//                          zero tens digit; units is always shown
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   start     conversion request, sampled only in IDLE
//   cin       carry-in operand
//   a, b      8-bit unsigned operands
//   busy      high while converting or presenting the result
//   done      one-cycle pulse, new digits valid
//   hundreds  BCD result digit, held until next done
//   tens      BCD result digit
//   units     BCD result digit
//   an        one-hot digit enable; bit0 = units, bit2 = hundreds
//   seg       segments {g,f,e,d,c,b,a}, active-high

module sum_display_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cin,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [2:0] an,
  output logic [6:0] seg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  state_t      state;
  logic [8:0]  bin;
  logic [11:0] bcd;
  logic [3:0]  iter;

  logic [11:0] bcd_adj;
  logic [11:0] bcd_shift;
  logic [8:0]  bin_shift;
  logic        unused_bcd_msb;

  logic [CW-1:0] scan_cnt;
  logic [3:0]    digit;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  function automatic logic [6:0] decode7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // One shift-add-3 step: correct each nibble first, then shift the
  // combined {bcd, bin} register left by one.
  always_comb begin
    bcd_adj   = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    bcd_shift = {bcd_adj[10:0], bin[8]};
    bin_shift = {bin[7:0], 1'b0};
  end

  // The top bit shifts out; a 9-bit input never reaches it.
  assign unused_bcd_msb = bcd_adj[11];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bin      <= '0;
      bcd      <= '0;
      iter     <= '0;
      hundreds <= '0;
      tens     <= '0;
      units    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin   <= {1'b0, a} + {1'b0, b} + {8'b0, cin};
            bcd   <= '0;
            iter  <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          bcd  <= bcd_shift;
          bin  <= bin_shift;
          iter <= iter + 4'd1;
          if (iter == 4'd8) begin
            // Final iteration: the digits land together with the done pulse.
            hundreds <= bcd_shift[11:8];
            tens     <= bcd_shift[7:4];
            units    <= bcd_shift[3:0];
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Display scan runs continuously, independent of the conversion FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      an       <= 3'b001;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt <= '0;
      an       <= {an[1:0], an[2]};
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    case (an)
      3'b010:  digit = tens;
      3'b100:  digit = hundreds;
      default: digit = units;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic blank;

  always_comb begin
    blank = (an[2] && (hundreds == 4'd0)) ||
            (an[1] && (hundreds == 4'd0) && (tens == 4'd0));
    seg   = blank ? 7'b0000000 : decode7(digit);
  end
`else
  always_comb begin
    seg = decode7(digit);
  end
`endif

endmodule

// File: tb/tb_sum_display_ctrl.sv
// tb/tb_sum_display_ctrl.sv - directed self-checking bench for sum_display_ctrl

module tb_sum_display_ctrl;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] units;
  logic [2:0] an;
  logic [6:0] seg;

  int vectors;
  int miscompares;
  int ndone;

  sum_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hundreds (hundreds),
    .tens     (tens),
    .units    (units),
    .an       (an),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] aa, input logic [7:0] bb, input logic cc);
    a     = aa;
    b     = bb;
    cin   = cc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 15) begin
      tick();
      n++;
    end
    chk(tag, done, 1);
    tick();
  endtask

  task automatic chk_digits(input string tag, input int h, input int t, input int u);
    chk({tag, "_h"}, hundreds, h);
    chk({tag, "_t"}, tens, t);
    chk({tag, "_u"}, units, u);
  endtask

  task automatic check_scan(input string tag, input logic [6:0] su,
                            input logic [6:0] st, input logic [6:0] sh);
    logic [2:0] prev;
    logic [6:0] exp_seg;
    logic [2:0] exp_an;
    int         found;
    prev  = an;
    found = 0;
    for (int i = 0; i < 16 && found == 0; i++) begin
      tick();
      if (prev == 3'b100 && an == 3'b001) found = 1;
      else prev = an;
    end
    chk({tag, "_align"}, found, 1);
    if (found == 1) begin
      for (int i = 0; i < 12; i++) begin
        case (i / 4)
          0:       begin exp_an = 3'b001; exp_seg = su; end
          1:       begin exp_an = 3'b010; exp_seg = st; end
          default: begin exp_an = 3'b100; exp_seg = sh; end
        endcase
        chk({tag, "_an"}, an, exp_an);
        chk({tag, "_seg"}, seg, exp_seg);
        tick();
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    cin   = 1'b0;
    a     = 8'd0;
    b     = 8'd0;

    // 1: reset state
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_digits("rst", 0, 0, 0);
    chk("rst_an", an, 3'b001);
    chk("rst_seg", seg, 7'b0111111);
    rst = 1'b0;
    tick();

    // 2: 255 + 255 + 1 = 511, exact latency
    do_start(8'd255, 8'd255, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      chk("t2_busy", busy, (k <= 10) ? 1 : 0);
      chk("t2_done", done, (k == 10) ? 1 : 0);
      if (k == 10) chk_digits("t2", 5, 1, 1);
      tick();
    end

    // 3: 100 + 23 = 123, start during CONV ignored
    do_start(8'd100, 8'd23, 1'b0);
    ndone = 0;
    for (int k = 1; k <= 25; k++) begin
      if (done) ndone++;
      if (k == 3) begin
        start = 1'b1;
        a     = 8'd0;
        b     = 8'd0;
      end else begin
        start = 1'b0;
      end
      if (k == 5) chk_digits("t3_hold", 5, 1, 1);
      if (k == 10) chk_digits("t3", 1, 2, 3);
      tick();
    end
    chk("t3_ndone", ndone, 1);
    chk_digits("t3_after", 1, 2, 3);

    // 4: reset mid-conversion of 200 + 0
    do_start(8'd200, 8'd0, 1'b0);
    for (int k = 1; k < 5; k++) tick();
    rst   = 1'b1;
    ndone = 0;
    for (int k = 0; k < 2; k++) begin
      if (done) ndone++;
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) ndone++;
      tick();
    end
    chk("t4_ndone", ndone, 0);
    chk("t4_busy", busy, 0);
    chk_digits("t4_rst", 0, 0, 0);
    do_start(8'd200, 8'd0, 1'b0);
    wait_done("t4_done");
    chk_digits("t4", 2, 0, 0);

    // 5: scan of 1/2/3
    do_start(8'd100, 8'd23, 1'b0);
    wait_done("t5_done");
    check_scan("t5", 7'b1001111, 7'b1011011, 7'b0000110);

    // 6: leading zeros, 7 and 0
    do_start(8'd7, 8'd0, 1'b0);
    wait_done("t6a_done");
    chk_digits("t6a", 0, 0, 7);
`ifdef LEADING_ZERO_BLANK_EN
    check_scan("t6a", 7'b0000111, 7'b0000000, 7'b0000000);
`else
    check_scan("t6a", 7'b0000111, 7'b0111111, 7'b0111111);
`endif
    do_start(8'd0, 8'd0, 1'b0);
    wait_done("t6b_done");
    chk_digits("t6b", 0, 0, 0);
`ifdef LEADING_ZERO_BLANK_EN
    check_scan("t6b", 7'b0111111, 7'b0000000, 7'b0000000);
`else
    check_scan("t6b", 7'b0111111, 7'b0111111, 7'b0111111);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
